// File: rtl/gs_dac_pkg.sv
// Shared constants, types and helpers for the General Sound sigma-delta DAC mixer.
// Slew limiting is enabled by defining GS_DAC_SLEW_EN.
package gs_dac_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int SAMPLE_W_DEF = 8;
  localparam int VOL_W_DEF    = 6;
  localparam int VOL_STEP_DEF = 31;
  localparam int SLEW_DIV_DEF = 16;

  typedef logic [SAMPLE_W_DEF-1:0] sample_t;
  typedef logic [VOL_W_DEF-1:0]    vol_t;

  // Direction the active sample takes toward its target on a slew tick.
  typedef enum logic [1:0] {
    SLEW_HOLD = 2'd0,
    SLEW_UP   = 2'd1,
    SLEW_DOWN = 2'd2
  } slew_dir_e;

  // Channel index width; a single channel still gets a 1-bit index port.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/gs_dac_channel.sv
// One DAC channel: sample/volume registers, volume-window enable and the
// first-order sigma-delta accumulator whose carry is the output bit (GS_DAC_SLEW_EN adds ramping).
module gs_dac_channel
  import gs_dac_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int VOL_W    = VOL_W_DEF
) (
  input  logic                clk32,
  input  logic                rst,
  input  logic                smp_we,
  input  logic [SAMPLE_W-1:0] smp_d,
  input  logic                vol_we,
  input  logic [VOL_W-1:0]    vol_d,
  input  logic                mute,
  input  logic [VOL_W-1:0]    vol_cnt,
`ifdef GS_DAC_SLEW_EN
  input  logic                slew_tick,
`endif
  output logic                dac_out,
  output logic                vol_top
);

  logic [SAMPLE_W-1:0] target;
  logic [SAMPLE_W-1:0] active;
  logic [VOL_W-1:0]    vol;
  logic                vol_en;
  logic [SAMPLE_W:0]   acc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      target <= '0;
      vol    <= '0;
    end else begin
      if (smp_we) target <= smp_d;
      if (vol_we) vol    <= vol_d;
    end
  end

`ifdef GS_DAC_SLEW_EN
  slew_dir_e slew_dir;

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    slew_dir = SLEW_HOLD;
    if (active < target)      slew_dir = SLEW_UP;
    else if (active > target) slew_dir = SLEW_DOWN;
  end

  // A target rewrite mid-ramp simply redirects from wherever active is now.
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      active <= '0;
    end else if (slew_tick) begin
      unique case (slew_dir)
        SLEW_UP:   active <= active + 1'b1;
        SLEW_DOWN: active <= active - 1'b1;
        default:   active <= active;
      endcase
    end
  end
`else
  assign active = target;
`endif

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) vol_en <= 1'b0;
    else     vol_en <= (vol_cnt < vol) && !mute;
  end

  // Outside the window only the carry is cleared; the low bits keep the modulator phase.
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (vol_en) begin
      acc <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, active};
    end else begin
      acc[SAMPLE_W] <= 1'b0;
    end
  end

  assign dac_out = acc[SAMPLE_W];
  assign vol_top = vol[VOL_W-1];

endmodule

// File: rtl/gs_dac_mixer.sv
// N-channel volume-scaled 1-bit DAC engine: shared volume-window counter, write decode
// and optional slew prescaler (GS_DAC_SLEW_EN) around one gs_dac_channel per output.
module gs_dac_mixer
  import gs_dac_pkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  parameter  int SAMPLE_W = SAMPLE_W_DEF,
  parameter  int VOL_W    = VOL_W_DEF,
  parameter  int VOL_STEP = VOL_STEP_DEF,
  parameter  int SLEW_DIV = SLEW_DIV_DEF,
  localparam int CH_W     = ch_w(CHANNELS)
) (
  input  logic                clk32,
  input  logic                rst,
  input  logic                smp_we,
  input  logic [CH_W-1:0]     smp_ch,
  input  logic [SAMPLE_W-1:0] smp_d,
  input  logic                vol_we,
  input  logic [CH_W-1:0]     vol_ch,
  input  logic [VOL_W-1:0]    vol_d,
  input  logic [CHANNELS-1:0] mute,
  output logic [CHANNELS-1:0] dac_out,
  output logic [CHANNELS-1:0] vol_top
);

  // An odd step visits every counter value once per 2^VOL_W cycles.
  if ((VOL_STEP % 2) == 0 || CHANNELS < 1 || CHANNELS > 16 || SLEW_DIV < 1) begin : g_bad_param
    $error("gs_dac_mixer: illegal parameter set");
  end

  localparam logic [VOL_W-1:0] VOL_INC = VOL_STEP[VOL_W-1:0];

  logic [VOL_W-1:0]    vol_cnt;
  logic [CHANNELS-1:0] smp_sel;
  logic [CHANNELS-1:0] vol_sel;

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) vol_cnt <= '0;
    else     vol_cnt <= vol_cnt + VOL_INC;
  end

  // Indices at or above CHANNELS match no channel, so they are dropped rather than aliased.
  always_comb begin
    smp_sel = '0;
    vol_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      smp_sel[i] = smp_we && (smp_ch == CH_W'(i));
      vol_sel[i] = vol_we && (vol_ch == CH_W'(i));
    end
  end

`ifdef GS_DAC_SLEW_EN
  localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             slew_tick;

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst)                    div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign slew_tick = (div_cnt == DIV_LAST);
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    gs_dac_channel #(
      .SAMPLE_W (SAMPLE_W),
      .VOL_W    (VOL_W)
    ) u_ch (
      .clk32    (clk32),
      .rst      (rst),
      .smp_we   (smp_sel[i]),
      .smp_d    (smp_d),
      .vol_we   (vol_sel[i]),
      .vol_d    (vol_d),
      .mute     (mute[i]),
      .vol_cnt  (vol_cnt),
`ifdef GS_DAC_SLEW_EN
      .slew_tick(slew_tick),
`endif
      .dac_out  (dac_out[i]),
      .vol_top  (vol_top[i])
    );
  end

endmodule

// File: tb/tb_gs_dac_mixer.sv
// Self-checking bench for gs_dac_mixer (3 channels): expected densities are queued when
// stimulus is applied and compared when the measurement window closes.
module tb_gs_dac_mixer;

  localparam int NCH      = 3;
  localparam int CH_W     = 2;
  localparam int SAMPLE_W = 8;
  localparam int VOL_W    = 6;
  localparam int FULL_WIN = (1 << VOL_W) * (1 << SAMPLE_W);

  logic                clk32 = 1'b0;
  logic                rst   = 1'b1;
  logic                smp_we = 1'b0;
  logic [CH_W-1:0]     smp_ch = '0;
  logic [SAMPLE_W-1:0] smp_d  = '0;
  logic                vol_we = 1'b0;
  logic [CH_W-1:0]     vol_ch = '0;
  logic [VOL_W-1:0]    vol_d  = '0;
  logic [NCH-1:0]      mute   = '0;
  logic [NCH-1:0]      dac_out;
  logic [NCH-1:0]      vol_top;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ones_cnt [NCH];
  logic [NCH-1:0] vt_seen;
  longint      exp_q [$];

  gs_dac_mixer #(
    .CHANNELS (NCH),
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W),
    .VOL_STEP (31),
    .SLEW_DIV (4)
  ) u_dut (
    .clk32   (clk32),
    .rst     (rst),
    .smp_we  (smp_we),
    .smp_ch  (smp_ch),
    .smp_d   (smp_d),
    .vol_we  (vol_we),
    .vol_ch  (vol_ch),
    .vol_d   (vol_d),
    .mute    (mute),
    .dac_out (dac_out),
    .vol_top (vol_top)
  );

  always #5 clk32 = ~clk32;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input longint v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input longint got);
    if (exp_q.size() == 0) check({tag, "_noexp"}, got, -1);
    else                   check(tag, got, exp_q.pop_front());
  endtask

  task automatic wr(input logic do_smp, input logic [CH_W-1:0] sc, input logic [SAMPLE_W-1:0] sd,
                    input logic do_vol, input logic [CH_W-1:0] vc, input logic [VOL_W-1:0] vd);
    @(negedge clk32);
    smp_we = do_smp; smp_ch = sc; smp_d = sd;
    vol_we = do_vol; vol_ch = vc; vol_d = vd;
    @(negedge clk32);
    smp_we = 1'b0;
    vol_we = 1'b0;
  endtask

  task automatic count_cycles(input int cycles);
    for (int c = 0; c < NCH; c++) ones_cnt[c] = 0;
    vt_seen = '0;
    repeat (cycles) begin
      @(negedge clk32);
      for (int c = 0; c < NCH; c++) ones_cnt[c] += int'(dac_out[c]);
      vt_seen |= vol_top;
    end
  endtask

  initial begin
    // Reset state and quiet run.
    repeat (3) @(negedge clk32);
    check("rst_dac_out", dac_out, 0);
    check("rst_vol_top", vol_top, 0);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) sb_push(0);
    sb_push(0);
    count_cycles(2000);
    for (int c = 0; c < NCH; c++) sb_check($sformatf("idle_ones_ch%0d", c), ones_cnt[c]);
    sb_check("idle_vol_top", vt_seen);

    // ch0 full volume, half-scale sample.
    wr(1'b1, 2'd0, 8'h80, 1'b1, 2'd0, 6'd63);
    sb_push(63 * 128);
    repeat (4) @(negedge clk32);
    count_cycles(FULL_WIN);
    sb_check("density_ch0", ones_cnt[0]);

    // Out-of-range index writes change nothing.
    wr(1'b1, 2'd3, 8'hFF, 1'b1, 2'd3, 6'd63);
    sb_push(0); sb_push(0); sb_push(3'b001);
    count_cycles(512);
    sb_check("oor_ones_ch1", ones_cnt[1]);
    sb_check("oor_ones_ch2", ones_cnt[2]);
    sb_check("oor_vol_top", vt_seen);

    // Same-cycle sample and volume writes to ch1 both land.
    wr(1'b1, 2'd1, 8'h40, 1'b1, 2'd1, 6'd32);
    sb_push(32 * 64); sb_push(63 * 128); sb_push(3'b011);
    repeat (4) @(negedge clk32);
    count_cycles(FULL_WIN);
    sb_check("both_we_ch1", ones_cnt[1]);
    sb_check("both_we_ch0", ones_cnt[0]);
    sb_check("both_we_vol_top", vt_seen);

    // ch2 full-scale sample at zero volume stays silent; volume 32 opens the window.
    wr(1'b1, 2'd2, 8'hFF, 1'b0, 2'd0, 6'd0);
    sb_push(0);
    count_cycles(1024);
    sb_check("vol0_ch2", ones_cnt[2]);
    wr(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 6'd32);
    sb_push(1); sb_push(32 * 255);
    repeat (4) @(negedge clk32);
    count_cycles(FULL_WIN);
    sb_check("vol_top_ch2", vt_seen[2]);
    sb_check("density_ch2", ones_cnt[2]);

    // Mute ch1 at full volume, then release and confirm density is intact.
    wr(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 6'd63);
    repeat (8) @(negedge clk32);
    mute[1] = 1'b1;
    sb_push(0);
    @(posedge clk32); @(posedge clk32); #1;
    sb_check("mute_next_edge", dac_out[1]);
    sb_push(0);
    count_cycles(512);
    sb_check("mute_ones_ch1", ones_cnt[1]);
    @(negedge clk32);
    mute[1] = 1'b0;
    sb_push(63 * 64);
    repeat (4) @(negedge clk32);
    count_cycles(FULL_WIN);
    sb_check("unmute_density_ch1", ones_cnt[1]);

    // Asynchronous reset mid-run clears outputs immediately.
    begin
      int budget;
      budget = 256;
      while (dac_out == '0 && budget > 0) begin
        @(negedge clk32);
        budget--;
      end
      sb_push(1);
      sb_check("mid_rst_active_before", budget > 0);
    end
    @(posedge clk32); #2;
    rst = 1'b1;
    #1;
    sb_push(0); sb_push(0);
    sb_check("mid_rst_dac_out", dac_out);
    sb_check("mid_rst_vol_top", vol_top);
    @(negedge clk32);
    rst = 1'b0;

`ifdef GS_DAC_SLEW_EN
    // Ramp 0 -> 10 then redirect to 3 once active reaches 6.
    wr(1'b1, 2'd0, 8'd10, 1'b0, 2'd0, 6'd0);
    repeat (44) @(negedge clk32);
    sb_push(10);
    sb_check("slew_up_to_10", u_dut.g_ch[0].u_ch.active);
    wr(1'b1, 2'd0, 8'd0, 1'b0, 2'd0, 6'd0);
    begin
      int budget;
      budget = 100;
      while (u_dut.g_ch[0].u_ch.active != 8'd6 && budget > 0) begin
        @(negedge clk32);
        budget--;
      end
      sb_push(1);
      sb_check("slew_reach_6", budget > 0);
    end
    wr(1'b1, 2'd0, 8'd3, 1'b0, 2'd0, 6'd0);
    repeat (8) @(negedge clk32);
    sb_push(1);
    sb_check("slew_ramp_down", u_dut.g_ch[0].u_ch.active < 8'd6);
    repeat (40) @(negedge clk32);
    sb_push(3);
    sb_check("slew_settle_3", u_dut.g_ch[0].u_ch.active);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
